// File: rtl/fpadd_share_ctrl.sv
// Round-robin front end that time-shares one free-running, 3-phase serial FP adder.
// Operands go onto the adder's single input bus in phase; sums come back tagged with the requester id.
module fpadd_share_ctrl #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDW  = $clog2(N_REQ)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [N_REQ*32-1:0]   i_req_a,
    input  logic [N_REQ*32-1:0]   i_req_b,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic                  o_rsp_valid,
    output logic [IDW-1:0]        o_rsp_id,
    output logic [31:0]           o_rsp_sum,
    output logic                  o_busy,
    output logic                  o_sync_err,
    output logic [31:0]           o_adder_a,
    input  logic                  i_adder_ready,
    input  logic [31:0]           i_adder_sum
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPA    = 2'd1,
        S_OPB    = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [DW-1:0]   r_b;

    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [DW-1:0]   w_op_a;
    logic [DW-1:0]   w_op_b;
    logic            w_grant;
    logic [IDW-1:0]  w_ptr_next;

    // First requester at or above the pointer, then wrap to the bottom of the vector.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_op_a  = '0;
        w_op_b  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!w_found && i_req_valid[i] && (i >= int'(r_ptr))) begin
                w_found = 1'b1;
                w_win   = IDW'(i);
                w_op_a  = i_req_a[DW*i +: DW];
                w_op_b  = i_req_b[DW*i +: DW];
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!w_found && i_req_valid[i]) begin
                w_found = 1'b1;
                w_win   = IDW'(i);
                w_op_a  = i_req_a[DW*i +: DW];
                w_op_b  = i_req_b[DW*i +: DW];
            end
        end
    end

    assign w_grant     = !i_reset && i_adder_ready && w_found &&
                         ((r_state == S_IDLE) || (r_state == S_RESULT));
    assign w_ptr_next  = (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + IDW'(1);
    assign o_req_ready = w_grant ? (N_REQ'(1) << w_win) : '0;
    assign o_busy      = (r_state != S_IDLE);

    // Any adder_ready level out of phase drops the operation and latches sync_err.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_b         <= '0;
            o_adder_a   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_sum   <= '0;
            o_sync_err  <= 1'b0;
        end else begin
            o_rsp_valid <= 1'b0;
            if (w_grant) begin
                r_b       <= w_op_b;
                r_id      <= w_win;
                r_ptr     <= w_ptr_next;
                o_adder_a <= w_op_a;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state <= S_OPA;
                    end
                end
                S_OPA: begin
                    if (i_adder_ready) begin
                        o_sync_err <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        o_adder_a <= r_b;
                        r_state   <= S_OPB;
                    end
                end
                S_OPB: begin
                    if (i_adder_ready) begin
                        o_sync_err <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_state <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (!i_adder_ready) begin
                        o_sync_err <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_sum   <= i_adder_sum;
                        o_rsp_id    <= r_id;
                        r_state     <= w_grant ? S_OPA : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_share_ctrl.sv
// Directed bench for fpadd_share_ctrl with a free-running 3-phase adder model.
module tb_fpadd_share_ctrl;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_sum;
    logic            busy;
    logic            sync_err;
    logic [31:0]     adder_a;
    logic            adder_ready;
    logic [31:0]     adder_sum;

    int checks = 0;
    int errors = 0;

    // Adder model: ready in phase 0, captures A in phase 1, B in phase 2.
    int          ph = 0;
    logic [31:0] m_opa = 32'h0;
    logic [31:0] m_sum = 32'h0;
    logic        force_ready = 1'b0;

    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h40000000_40000000: return 32'h40800000;
            64'h3FC00000_BF000000: return 32'h3F800000;
            64'h41200000_40A00000: return 32'h41700000;
            default:               return a ^ b ^ 32'hDEADBEEF;
        endcase
    endfunction

    assign adder_ready = (ph == 0) || force_ready;
    assign adder_sum   = m_sum;

    always @(posedge clk) begin
        if (ph == 1) m_opa <= adder_a;
        if (ph == 2) m_sum <= fake_add(m_opa, adder_a);
        ph <= (ph == 2) ? 0 : ph + 1;
    end

    always #5 clk = ~clk;

    fpadd_share_ctrl #(.N_REQ(N)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_req_valid   (req_valid),
        .i_req_a       (req_a),
        .i_req_b       (req_b),
        .o_req_ready   (req_ready),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_id      (rsp_id),
        .o_rsp_sum     (rsp_sum),
        .o_busy        (busy),
        .o_sync_err    (sync_err),
        .o_adder_a     (adder_a),
        .i_adder_ready (adder_ready),
        .i_adder_sum   (adder_sum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        #1;
        while (adder_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        if (n >= 8) begin
            checks++;
            errors++;
            $error("FAIL wait_ready: observed=timeout expected=adder_ready");
        end
    endtask

    task automatic chk_rsp(input string tag, input int id, input logic [31:0] sum);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_sum"}, rsp_sum, sum);
    endtask

    logic [31:0] exp_sum [N];

    initial begin
        exp_sum[0] = 32'h40400000;
        exp_sum[1] = 32'h40800000;
        exp_sum[2] = 32'h3F800000;
        exp_sum[3] = 32'h41700000;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_a[0*32 +: 32] = 32'h3F800000; req_b[0*32 +: 32] = 32'h40000000;
        req_a[1*32 +: 32] = 32'h40000000; req_b[1*32 +: 32] = 32'h40000000;
        req_a[2*32 +: 32] = 32'h3FC00000; req_b[2*32 +: 32] = 32'hBF000000;
        req_a[3*32 +: 32] = 32'h41200000; req_b[3*32 +: 32] = 32'h40A00000;

        // Reset values
        tick(); tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_sum", rsp_sum, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk("rst_adder_a", adder_a, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // 1. Single add, latency T -> T+4
        wait_ready();
        req_valid = 4'b0001;
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("t1_adder_a_A", adder_a, 32'h3F800000);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_req_ready_off", 32'(req_ready), 32'd0);
        tick();
        chk("t1_adder_a_B", adder_a, 32'h40000000);
        tick();
        chk("t1_no_early_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk_rsp("t1_rsp", 0, 32'h40400000);
        tick();
        chk("t1_rsp_one_cycle", 32'(rsp_valid), 32'd0);

        // 2. Round robin with all requests held from reset
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("t2_ready_in_reset", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        wait_ready();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_grant%0d", k), 32'(req_ready), 32'(1) << (k % 4));
            tick();
            if (k > 0) chk_rsp($sformatf("t2_rsp%0d", k - 1), k - 1, exp_sum[k-1]);
            else chk("t2_rsp_none", 32'(rsp_valid), 32'd0);
            if (k == 4) req_valid = '0;
            tick();
            tick();
        end
        chk("t2_no_grant", 32'(req_ready), 32'd0);
        tick();
        chk_rsp("t2_rsp_last", 0, 32'h40400000);

        // 3. Pointer wrap and fairness
        wait_ready();
        req_valid = 4'b1000;
        #1;
        chk("t3_grant3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b1010;
        tick();
        tick();
        chk("t3_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1000;
        chk_rsp("t3_rsp3", 3, 32'h41700000);
        tick();
        tick();
        #1;
        chk("t3_grant3b", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        chk_rsp("t3_rsp1", 1, 32'h40800000);
        tick();
        tick();
        tick();
        chk_rsp("t3_rsp3b", 3, 32'h41700000);
        chk("t3_idle", 32'(busy), 32'd0);

        // 4. Phase-lock loss during OPA
        wait_ready();
        req_valid = 4'b0001;
        #1;
        chk("t4_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        force_ready = 1'b1;
        tick();
        force_ready = 1'b0;
        #1;
        chk("t4_sync_err", 32'(sync_err), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t4_no_rsp%0d", k), 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b0100;
        wait_ready();
        chk("t4_grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        chk_rsp("t4_rsp2", 2, 32'h3F800000);
        chk("t4_sync_err_sticky", 32'(sync_err), 32'd1);

        // 5. Reset during OPB
        req_valid = 4'b0010;
        wait_ready();
        chk("t5_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        chk("t5_busy_opb", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_adder_a", adder_a, 32'd0);
        chk("t5_rst_sync_err", 32'(sync_err), 32'd0);
        chk("t5_rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("t5_rst_rsp_sum", rsp_sum, 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("t5_no_rsp%0d", k), 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b1100;
        wait_ready();
        chk("t5_grant_lowest", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        chk_rsp("t5_rsp2", 2, 32'h3F800000);

        // 6. Withdrawal and operand stability
        wait_ready();
        tick();
        req_valid = 4'b0010;
        #1;
        chk("t6_no_grant_offphase", 32'(req_ready), 32'd0);
        tick();
        req_valid = '0;
        tick();
        chk("t6_withdrawn", 32'(req_ready), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);
        req_valid = 4'b1000;
        #1;
        chk("t6_grant3", 32'(req_ready), 32'h8);
        tick();
        req_a[3*32 +: 32] = 32'h0;
        req_b[3*32 +: 32] = 32'hFFFFFFFF;
        req_valid = '0;
        #1;
        chk("t6_adder_a_A", adder_a, 32'h41200000);
        tick();
        chk("t6_adder_a_B", adder_a, 32'h40A00000);
        tick();
        tick();
        chk_rsp("t6_rsp3", 3, 32'h41700000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
